// File: rtl/fact_host_if.sv
// fact_host_if: groups the client request/response handshake and the
// accelerator register port driven by fact_host.
//   slave  : the view seen by fact_host itself
//   master : the view seen by the client plus the accelerator (bench side)
interface fact_host_if;
    logic        req_valid;
    logic [3:0]  req_n;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic        resp_err;
    logic        resp_timeout;
    logic        resp_ready;
    logic [1:0]  a;
    logic        we;
    logic [3:0]  wd;
    logic [31:0] rd;

    modport slave (
        input  req_valid, req_n, resp_ready, rd,
        output req_ready, resp_valid, resp_result, resp_err, resp_timeout,
               a, we, wd
    );

    modport master (
        output req_valid, req_n, resp_ready, rd,
        input  req_ready, resp_valid, resp_result, resp_err, resp_timeout,
               a, we, wd
    );
endinterface

// File: rtl/fact_host.sv
// fact_host: bus initiator for the memory-mapped factorial accelerator.
// Takes n from a client, writes n and go, polls status, reads the result
// and hands it back over a valid/ready response.
// Optional poll timeout: define FACT_HOST_TIMEOUT_EN to compile in a
// 16-bit poll counter and the TIMEOUT_CYCLES parameter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, req_ready=1, bus idle
// WR_N   | writing latched n to ADDR_N
// WR_GO  | writing 1 to ADDR_GO (also clears stale done/err)
// POLL   | reading ADDR_STAT until err, done (or timeout)
// RD_RES | reading ADDR_RES into resp_result
// RESP   | resp_valid=1, holding the response until resp_ready
module fact_host #(
    parameter logic [1:0] ADDR_N    = 2'b00,
    parameter logic [1:0] ADDR_GO   = 2'b01,
    parameter logic [1:0] ADDR_STAT = 2'b10,
    parameter logic [1:0] ADDR_RES  = 2'b11
`ifdef FACT_HOST_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic       clk,
    input  logic       rst,
    fact_host_if.slave host
);

    typedef enum logic [2:0] {
        IDLE,
        WR_N,
        WR_GO,
        POLL,
        RD_RES,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  n_q, n_d;
    logic        accept;
    logic        set_res, set_err, set_to;

    logic [1:0]  a_q, a_d;
    logic        we_q, we_d;
    logic [3:0]  wd_q, wd_d;
    logic        resp_valid_q;
    logic [31:0] result_q;
    logic        err_q;
    logic        timeout_q;

`ifdef FACT_HOST_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] poll_cnt;
`endif

    assign accept = (state_q == IDLE) && host.req_valid;
    // n is captured on the acceptance edge so WR_N can drive it right away
    assign n_d    = accept ? host.req_n : n_q;

    assign host.req_ready    = (state_q == IDLE);
    assign host.resp_valid   = resp_valid_q;
    assign host.resp_result  = result_q;
    assign host.resp_err     = err_q;
    assign host.resp_timeout = timeout_q;
    assign host.a            = a_q;
    assign host.we           = we_q;
    assign host.wd           = wd_q;

    // Next-state logic and response-load strobes
    always_comb begin
        state_d = state_q;
        set_res = 1'b0;
        set_err = 1'b0;
        set_to  = 1'b0;
        case (state_q)
            IDLE: begin
                if (host.req_valid) state_d = WR_N;
            end
            WR_N:  state_d = WR_GO;
            WR_GO: state_d = POLL;
            POLL: begin
                // err wins over done; both win over a timeout on the same cycle
                if (host.rd[1]) begin
                    state_d = RESP;
                    set_err = 1'b1;
                end else if (host.rd[0]) begin
                    state_d = RD_RES;
`ifdef FACT_HOST_TIMEOUT_EN
                end else if (poll_cnt == TO_LAST) begin
                    state_d = RESP;
                    set_to  = 1'b1;
`endif
                end
            end
            RD_RES: begin
                state_d = RESP;
                set_res = 1'b1;
            end
            RESP: begin
                if (host.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus value for the state being entered, so it is registered for the whole cycle
    always_comb begin
        a_d  = 2'b00;
        we_d = 1'b0;
        wd_d = 4'd0;
        case (state_d)
            WR_N: begin
                a_d  = ADDR_N;
                we_d = 1'b1;
                wd_d = n_d;
            end
            WR_GO: begin
                a_d  = ADDR_GO;
                we_d = 1'b1;
                wd_d = 4'b0001;
            end
            POLL:    a_d = ADDR_STAT;
            RD_RES:  a_d = ADDR_RES;
            default: ;
        endcase
    end

    // State, latched n and registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= 4'd0;
            a_q          <= 2'b00;
            we_q         <= 1'b0;
            wd_q         <= 4'd0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            a_q          <= a_d;
            we_q         <= we_d;
            wd_q         <= wd_d;
            resp_valid_q <= (state_d == RESP);
        end
    end

    // Response payload, loaded once on the way into RESP and held there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= 32'd0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (set_res) begin
            result_q  <= host.rd;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (set_err) begin
            result_q  <= 32'd0;
            err_q     <= 1'b1;
            timeout_q <= 1'b0;
        end else if (set_to) begin
            result_q  <= 32'd0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
        end
    end

`ifdef FACT_HOST_TIMEOUT_EN
    // Consecutive idle-status POLL cycles; restarts for every new request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= 16'd0;
        end else if (state_d == WR_N) begin
            poll_cnt <= 16'd0;
        end else if (state_q == POLL && state_d == POLL) begin
            poll_cnt <= poll_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fact_host.sv
// tb_fact_host: directed bench for fact_host with a small accelerator model.
// With FACT_HOST_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8.
module tb_fact_host;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    fact_host_if hif();

`ifdef FACT_HOST_TIMEOUT_EN
    fact_host #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .host(hif));
`else
    fact_host dut (.clk(clk), .rst(rst), .host(hif));
`endif

    always #5 clk = ~clk;

    // Accelerator model: done (and err for n>12) appears m_delay cycles after go
    logic [3:0] m_n     = 4'd0;
    logic       m_done  = 1'b0;
    logic       m_err   = 1'b0;
    logic       m_busy  = 1'b0;
    int         m_cnt   = 0;
    int         m_delay = 1;   // 0 = never finishes

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] p = 32'd1;
        for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
        return p;
    endfunction

    always @(posedge clk) begin
        if (hif.we && hif.a == 2'b00) m_n <= hif.wd;
        if (hif.we && hif.a == 2'b01) begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= m_delay;
        end else if (m_busy && m_delay != 0) begin
            if (m_cnt <= 1) begin
                m_done <= 1'b1;
                m_err  <= (m_n > 4'd12);
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always_comb begin
        hif.rd = 32'd0;
        case (hif.a)
            2'b00: hif.rd = {28'd0, m_n};
            2'b01: hif.rd = 32'd1;
            2'b10: hif.rd = {30'd0, m_err, m_done};
            2'b11: hif.rd = fact(m_n);
            default: hif.rd = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present n, wait for req_ready, return just after the acceptance edge
    task automatic send_req(input logic [3:0] n);
        int w = 0;
        @(negedge clk);
        hif.req_valid = 1'b1;
        hif.req_n     = n;
        while (!hif.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_accept", {31'd0, hif.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        hif.req_valid = 1'b0;
        hif.req_n     = 4'd0;
    endtask

    // Wait at negedges for resp_valid; report RD_RES use, POLL count, req_ready leaks
    task automatic wait_resp(input int budget, output bit saw_res, output int polls,
                             output bit ready_leak);
        int w = 0;
        saw_res = 1'b0;
        polls = 0;
        ready_leak = 1'b0;
        while (!hif.resp_valid && w < budget) begin
            @(negedge clk);
            w++;
            if (hif.a == 2'b11) saw_res = 1'b1;
            if (hif.a == 2'b10) polls++;
            if (hif.req_ready && !hif.resp_valid) ready_leak = 1'b1;
        end
        chk("resp_wait", {31'd0, hif.resp_valid}, 32'd1);
    endtask

    task automatic release_resp();
        hif.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        hif.resp_ready = 1'b0;
        @(negedge clk);
        chk("resp_drop", {30'd0, hif.resp_valid, hif.req_ready}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   saw_res, leak;
        int   polls;
        logic [1:0] t1_a  [1:8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        logic       t1_we [1:8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        hif.req_valid  = 1'b0;
        hif.req_n      = 4'd0;
        hif.resp_ready = 1'b0;

        // reset state
        #12;
        chk("rst_bus", {25'd0, hif.a, hif.we, hif.wd}, 32'd0);
        chk("rst_resp", {29'd0, hif.resp_valid, hif.resp_err, hif.resp_timeout}, 32'd0);
        chk("rst_result", hif.resp_result, 32'd0);
        chk("rst_req_ready", {31'd0, hif.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // n=5, done seen on 4th POLL cycle, bus trace and resp_valid at E+8
        m_delay = 3;
        send_req(4'd5);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("t1_bus_c%0d", c), {28'd0, hif.a, hif.we, hif.resp_valid},
                {28'd0, t1_a[c], t1_we[c], (c == 8)});
            if (c == 1) chk("t1_wd_n", {28'd0, hif.wd}, 32'd5);
            if (c == 2) chk("t1_wd_go", {28'd0, hif.wd}, 32'd1);
        end
        chk("t1_result", hif.resp_result, 32'h00000078);
        chk("t1_err_to", {30'd0, hif.resp_err, hif.resp_timeout}, 32'd0);
        release_resp();

        // n=0 then n=12 back-to-back with resp_ready held high
        hif.resp_ready = 1'b1;
        m_delay = 1;
        send_req(4'd0);
        wait_resp(40, saw_res, polls, leak);
        chk("t2_result0", hif.resp_result, 32'h00000001);
        chk("t2_ready_busy0", {31'd0, leak}, 32'd0);
        m_delay = 2;
        send_req(4'd12);
        wait_resp(40, saw_res, polls, leak);
        chk("t2_result12", hif.resp_result, 32'h1C8CFC00);
        chk("t2_ready_busy12", {31'd0, leak}, 32'd0);
        @(negedge clk);
        hif.resp_ready = 1'b0;

        // n=13: accelerator flags err and done together
        m_delay = 2;
        send_req(4'd13);
        wait_resp(40, saw_res, polls, leak);
        chk("t3_err_to", {30'd0, hif.resp_err, hif.resp_timeout}, 32'b10);
        chk("t3_result", hif.resp_result, 32'd0);
        chk("t3_no_rd_res", {31'd0, saw_res}, 32'd0);
        release_resp();

        // n=4 with resp_ready low for 10 cycles: response held, bus idle
        m_delay = 2;
        send_req(4'd4);
        wait_resp(40, saw_res, polls, leak);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4_hold_%0d", i), {27'd0, hif.resp_valid, hif.req_ready, hif.a, hif.we},
                {27'd0, 1'b1, 1'b0, 2'b00, 1'b0});
            chk($sformatf("t4_result_%0d", i), hif.resp_result, 32'h00000018);
            @(negedge clk);
        end
        release_resp();

        // reset during POLL for n=6, then n=3 afresh
        m_delay = 10;
        send_req(4'd6);
        repeat (4) @(negedge clk);
        chk("t5_in_poll", {30'd0, hif.a}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_bus", {25'd0, hif.a, hif.we, hif.wd}, 32'd0);
        chk("t5_rst_resp", {29'd0, hif.resp_valid, hif.resp_err, hif.resp_timeout}, 32'd0);
        chk("t5_rst_result", hif.resp_result, 32'd0);
        chk("t5_rst_ready", {31'd0, hif.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        m_delay = 3;
        send_req(4'd3);
        wait_resp(40, saw_res, polls, leak);
        chk("t5_result3", hif.resp_result, 32'h00000006);
        chk("t5_err_to", {30'd0, hif.resp_err, hif.resp_timeout}, 32'd0);
        release_resp();

        // accelerator never finishes
        m_delay = 0;
        send_req(4'd7);
`ifdef FACT_HOST_TIMEOUT_EN
        wait_resp(50, saw_res, polls, leak);
        chk("t6_poll_count", 32'(polls), 32'd8);
        chk("t6_err_to", {30'd0, hif.resp_err, hif.resp_timeout}, 32'b11);
        chk("t6_result", hif.resp_result, 32'd0);
        release_resp();
`else
        repeat (2000) @(negedge clk);
        chk("t6_still_poll", {29'd0, hif.a, hif.resp_valid}, {29'd0, 2'b10, 1'b0});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_after_rst", {29'd0, hif.a, hif.req_ready}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
